// File: rtl/data_mem_responder.sv
// Purpose : load/store responder in front of a word RAM (SB/SH/SW, LB/LH/LW/LBU/LHU) with error flagging.
// Latency : rsp_valid rises WAIT_STATES+1 cycles after the request acceptance edge.
// Backpr. : one request in flight; req_ready only in IDLE, response held until rsp_ready.
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready, req_addr, req_we, req_funct3, req_wdata : request channel
//   rsp_valid/rsp_ready, rsp_rdata, rsp_err                       : response channel
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_addr;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_wdata;
    logic [3:0]  r_cnt;

    // Backing store; contents deliberately survive reset.
    logic [31:0] r_mem [DEPTH_WORDS];

    logic             w_accept;
    logic             w_access;
    logic             w_rsp_done;
    logic             w_legal;
    logic             w_is_half;
    logic             w_is_word;
    logic             w_misal;
    logic             w_oor;
    logic             w_err;
    logic [31:0]      w_word_idx;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_rd_word;
    logic [31:0]      w_shifted;
    logic [31:0]      w_load_data;
    logic [31:0]      w_wr_word;
    logic             w_mem_we;

    assign w_accept   = req_valid && (r_state == S_IDLE);
    assign w_access   = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_rsp_done = (r_state == S_RESP) && rsp_ready;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Access decode on the latched request
    // ------------------------------------------------------------------
    always_comb begin
        w_legal   = 1'b0;
        w_is_half = 1'b0;
        w_is_word = 1'b0;
        case (r_funct3)
            3'b000: w_legal = 1'b1;
            3'b001: begin w_legal = 1'b1;   w_is_half = 1'b1; end
            3'b010: begin w_legal = 1'b1;   w_is_word = 1'b1; end
            3'b100: w_legal = !r_we;                           // LBU has no store twin
            3'b101: begin w_legal = !r_we;  w_is_half = 1'b1; end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_misal    = (w_is_half && r_addr[0]) || (w_is_word && (r_addr[1:0] != 2'b00));
    assign w_word_idx = {2'b00, r_addr[31:2]};
    assign w_oor      = (w_word_idx >= 32'(DEPTH_WORDS));
    assign w_err      = !w_legal || w_misal || w_oor;

    assign w_idx      = r_addr[IDX_W+1:2];
    assign w_rd_word  = r_mem[w_idx];
    assign w_shifted  = w_rd_word >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_load_data = 32'd0;
        case (r_funct3)
            3'b000: w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001: w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b010: w_load_data = w_rd_word;
            3'b100: w_load_data = {24'd0, w_shifted[7:0]};
            3'b101: w_load_data = {16'd0, w_shifted[15:0]};
            default: w_load_data = 32'd0;
        endcase
    end

    // Read-modify-write merge so untouched byte lanes keep their contents.
    always_comb begin
        w_wr_word = w_rd_word;
        case (r_funct3[1:0])
            2'b00:   w_wr_word[{r_addr[1:0], 3'b000} +: 8]  = r_wdata[7:0];
            2'b01:   w_wr_word[{r_addr[1], 4'b0000} +: 16]  = r_wdata[15:0];
            default: w_wr_word = r_wdata;
        endcase
    end

    // r_state is async-reset, so a reset during WAIT can never let a store commit.
    assign w_mem_we = w_access && r_we && !w_err;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= w_wr_word;
        end
    end

    // ------------------------------------------------------------------
    // Request latch, wait counter and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr    <= 32'd0;
            r_we      <= 1'b0;
            r_funct3  <= 3'd0;
            r_wdata   <= 32'd0;
            r_cnt     <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr   <= req_addr;
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_wdata  <= req_wdata;
                r_cnt    <= 4'(WAIT_STATES);
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_access) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= (w_err || r_we) ? 32'd0 : w_load_data;
                rsp_err   <= w_err;
            end else if (w_rsp_done) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_ready = 1'b0;
    bit          sel = 1'b0;        // 0: WAIT_STATES=1 instance, 1: WAIT_STATES=0 instance

    logic [1:0]  dut_rr;
    logic [1:0]  dut_vld;
    logic [1:0]  dut_err;
    logic [31:0] dut_rd0, dut_rd1;
    logic        s_rr, s_vld, s_err;
    logic [31:0] s_rd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u_dut0 (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid && !sel), .req_ready(dut_rr[0]),
        .req_addr(req_addr), .req_we(req_we), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .rsp_valid(dut_vld[0]), .rsp_ready(rsp_ready && !sel),
        .rsp_rdata(dut_rd0), .rsp_err(dut_err[0])
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut1 (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid && sel), .req_ready(dut_rr[1]),
        .req_addr(req_addr), .req_we(req_we), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .rsp_valid(dut_vld[1]), .rsp_ready(rsp_ready && sel),
        .rsp_rdata(dut_rd1), .rsp_err(dut_err[1])
    );

    assign s_rr  = sel ? dut_rr[1]  : dut_rr[0];
    assign s_vld = sel ? dut_vld[1] : dut_vld[0];
    assign s_err = sel ? dut_err[1] : dut_err[0];
    assign s_rd  = sel ? dut_rd1    : dut_rd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t sel=%0d)", name, act, exp, $time, sel);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t sel=%0d)", name, $time, sel);
    endtask

    // ------------------------------------------------------------------
    // Reference model: byte-addressed semantics on a plain word array,
    // with response timing expressed as "acceptance cycle + WS + 1".
    // ------------------------------------------------------------------
    logic [31:0] mm [2][DEPTH];

    function automatic void model_access(input bit s, input logic [31:0] a, input bit we,
                                         input logic [2:0] f3, input logic [31:0] wd,
                                         output logic [31:0] rd, output bit er);
        int size;
        int off;
        int widx;
        logic [31:0] w;
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        if (we && f3 > 3'd2) size = 0;
        off = int'(a[1:0]);
        if (size == 0) er = 1'b1;
        else           er = ((off % size) != 0) || ((a >> 2) >= 32'(DEPTH));
        rd = 32'd0;
        if (!er) begin
            widx = int'(a >> 2);
            w = mm[s][widx];
            if (we) begin
                for (int i = 0; i < size; i++) w[8*(off+i) +: 8] = wd[8*i +: 8];
                mm[s][widx] = w;
            end else begin
                v = w >> (8 * off);
                if (size == 1) begin
                    v = v & 32'hFF;
                    if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
                end else if (size == 2) begin
                    v = v & 32'hFFFF;
                    if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
                end
                rd = v;
            end
        end
    endfunction

    int          cyc = 0;
    bit          m_busy = 1'b0;
    bit          m_vld = 1'b0;
    int          m_tacc = 0;
    logic [31:0] m_addr, m_wdata, m_rdata;
    bit          m_we, m_err;
    logic [2:0]  m_f3;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_vld  = 1'b0;
        end else begin
            cyc++;
            if (m_busy && m_vld) begin
                if (rsp_ready) begin
                    m_busy = 1'b0;
                    m_vld  = 1'b0;
                end
            end else if (m_busy) begin
                if (cyc == m_tacc + (sel ? 0 : 1) + 1) begin
                    model_access(sel, m_addr, m_we, m_f3, m_wdata, m_rdata, m_err);
                    m_vld = 1'b1;
                end
            end else if (req_valid) begin
                m_busy  = 1'b1;
                m_tacc  = cyc;
                m_addr  = req_addr;
                m_we    = req_we;
                m_f3    = req_funct3;
                m_wdata = req_wdata;
            end
        end
    end

    // Single compare process: every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("req_ready", {31'd0, s_rr}, {31'd0, !m_busy});
            chk("rsp_valid", {31'd0, s_vld}, {31'd0, m_vld});
            if (m_vld) begin
                chk("rsp_rdata", s_rd, m_rdata);
                chk("rsp_err", {31'd0, s_err}, {31'd0, m_err});
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic txn(input logic [31:0] a, input bit we, input logic [2:0] f3,
                       input logic [31:0] wd, input int hold, input bit probe,
                       output logic [31:0] rd, output logic er);
        int n;
        rd = '0;
        er = 1'b1;
        req_addr = a; req_we = we; req_funct3 = f3; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        while (!s_rr && n < 50) begin @(posedge clk); #1; n++; end
        if (!s_rr) begin timeout_fail("accept"); req_valid = 1'b0; return; end
        @(posedge clk); #1;
        // Scramble fields: the DUT must not look at them after acceptance.
        req_valid = 1'b0;
        req_addr = $urandom; req_we = 1'($urandom); req_funct3 = 3'($urandom); req_wdata = $urandom;
        n = 0;
        while (!s_vld && n < 50) begin @(posedge clk); #1; n++; end
        if (!s_vld) begin timeout_fail("response"); return; end
        for (int i = 0; i < hold; i++) begin
            if (probe) req_valid = 1'b1;
            @(posedge clk); #1;
        end
        rd = s_rd;
        er = s_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_rst_vld"}, {31'd0, s_vld}, 32'd0);
        chk({tag, "_rst_rdy"}, {31'd0, s_rr}, 32'd1);
        chk({tag, "_rst_rdata"}, s_rd, 32'd0);
        chk({tag, "_rst_err"}, {31'd0, s_err}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [29:0] w;
        int          r;

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < DEPTH; i++) mm[s][i] = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        sel = 1'b0; reset_check("init0");
        sel = 1'b1; reset_check("init1");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Give every word the bench touches a known value in both instances.
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            for (int i = 0; i < 36; i++) begin
                w = (i < 32) ? 30'(i) : 30'(1020 + i - 32);
                txn({w, 2'b00}, 1'b1, 3'b010, $urandom, 0, 1'b0, rd, er);
            end
        end

        sel = 1'b0;
        // 1: store then load back
        txn(32'h10, 1'b1, 3'b010, 32'hDEAD_BEEF, 0, 1'b0, rd, er);
        txn(32'h10, 1'b0, 3'b010, 32'h0, 0, 1'b0, rd, er);
        chk("t1_lw_data", rd, 32'hDEAD_BEEF);
        chk("t1_lw_err", {31'd0, er}, 32'd0);

        // 2: byte store into a zero word, then signed/unsigned/word loads
        txn(32'h20, 1'b1, 3'b010, 32'h0, 0, 1'b0, rd, er);
        txn(32'h21, 1'b1, 3'b000, 32'hAAAA_AA80, 0, 1'b0, rd, er);
        txn(32'h21, 1'b0, 3'b000, 32'h0, 0, 1'b0, rd, er);
        chk("t2_lb", rd, 32'hFFFF_FF80);
        txn(32'h21, 1'b0, 3'b100, 32'h0, 0, 1'b0, rd, er);
        chk("t2_lbu", rd, 32'h0000_0080);
        txn(32'h20, 1'b0, 3'b010, 32'h0, 0, 1'b0, rd, er);
        chk("t2_lw", rd, 32'h0000_8000);

        // 3: error cases leave RAM untouched
        txn(32'h13, 1'b0, 3'b001, 32'h0, 0, 1'b0, rd, er);
        chk("t3_lh_mis_err", {31'd0, er}, 32'd1);
        chk("t3_lh_mis_data", rd, 32'd0);
        txn(32'h22, 1'b1, 3'b010, 32'h1111_2222, 0, 1'b0, rd, er);
        chk("t3_sw_mis_err", {31'd0, er}, 32'd1);
        txn(32'h0, 1'b0, 3'b011, 32'h0, 0, 1'b0, rd, er);
        chk("t3_f3_err", {31'd0, er}, 32'd1);
        chk("t3_f3_data", rd, 32'd0);
        txn(32'h20, 1'b0, 3'b010, 32'h0, 0, 1'b0, rd, er);
        chk("t3_ram_kept", rd, 32'h0000_8000);

        // 4: range boundary
        txn(32'(DEPTH * 4), 1'b0, 3'b010, 32'h0, 0, 1'b0, rd, er);
        chk("t4_oor_err", {31'd0, er}, 32'd1);
        txn(32'((DEPTH - 1) * 4), 1'b0, 3'b010, 32'h0, 0, 1'b0, rd, er);
        chk("t4_last_err", {31'd0, er}, 32'd0);

        // 5: response backpressure with a competing request during RESP
        txn(32'h10, 1'b0, 3'b001, 32'h0, 5, 1'b1, rd, er);
        chk("t5_lh_data", rd, 32'hFFFF_BEEF);

        // 6: reset during WAIT aborts a store, on both wait-state settings
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            txn(32'h40, 1'b1, 3'b010, 32'hCAFE_F00D, 0, 1'b0, rd, er);
            txn(32'h40, 1'b0, 3'b010, 32'h0, 0, 1'b0, rd, er);
            req_addr = 32'h40; req_we = 1'b1; req_funct3 = 3'b010; req_wdata = 32'h1234_5678;
            req_valid = 1'b1;
            @(posedge clk); #1;
            req_valid = 1'b0;
            rst_n = 1'b0;
            #1;
            reset_check(s == 0 ? "t6_ws1" : "t6_ws0");
            #2;
            rst_n = 1'b1;
            @(posedge clk); #1;
            txn(32'h40, 1'b0, 3'b010, 32'h0, 0, 1'b0, rd, er);
            chk("t6_lw_prior", rd, 32'hCAFE_F00D);
        end

        // Random traffic, model-checked every cycle
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            for (int k = 0; k < 200; k++) begin
                r = $urandom_range(0, 19);
                if (r < 14)      w = 30'($urandom_range(0, 31));
                else if (r < 17) w = 30'($urandom_range(1020, 1023));
                else if (r < 19) w = 30'($urandom_range(1024, 1100));
                else             w = 30'h3FFF_FFFF;
                txn({w, 2'($urandom)}, 1'($urandom), 3'($urandom), $urandom,
                    $urandom_range(0, 3), 1'($urandom), rd, er);
            end
        end

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
